// File: rtl/cache_def.sv
// cache_def
//   Shared types for the downstream direct-mapped cache and its backing
//   memory responder.
//   mem_req_type  : cache -> memory request (addr, 128-bit line data, rw, valid)
//   mem_data_type : memory -> cache response (128-bit line data, ready)
package cache_def;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;     // 1 = write-back, 0 = line read
    logic         valid;  // single-cycle strobe
  } mem_req_type;

  typedef struct packed {
    logic [127:0] data;
    logic         ready;  // single-cycle completion pulse
  } mem_data_type;

  localparam int MEM_LATENCY_DEFAULT = 4;

  typedef enum logic [1:0] {
    mr_idle,
    mr_busy,
    mr_resp
  } mem_resp_state_type;

endpackage

// File: rtl/dm_mem_array_downstream.sv
// dm_mem_array_downstream
//   Line storage behind the memory responder: 2**IDX_W lines of 128 bits.
//   Contents start at zero and are never cleared by reset.
//   Ports:
//     clk    : rising-edge clock
//     we     : write enable, plain overwrite of the addressed line
//     waddr  : write line index
//     wdata  : write line data
//     raddr  : read line index (asynchronous read)
//     rdata  : current contents of line raddr
module dm_mem_array_downstream #(
  parameter int IDX_W = 14
) (
  input  logic               clk,
  input  logic               we,
  input  logic [IDX_W-1:0]   waddr,
  input  logic [127:0]       wdata,
  input  logic [IDX_W-1:0]   raddr,
  output logic [127:0]       rdata
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [127:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads see the array as it stands at the start of the cycle, so a
  // write committed on this edge is visible only from the next cycle.
  assign rdata = mem[raddr];

endmodule

// File: rtl/dm_mem_responder_downstream.sv
// dm_mem_responder_downstream
//   Backing-memory responder on the memory side of the downstream
//   direct-mapped cache. Accepts one line request at a time and answers it
//   LATENCY cycles after acceptance with a one-cycle ready pulse.
//   Ports:
//     clk       : rising-edge clock
//     rst       : synchronous reset, active-high
//     mem_req   : request from cache FSM (addr, data, rw, valid strobe)
//     mem_data  : response (line data on reads, zero otherwise; ready pulse)
//     busy      : a request is outstanding (state is not idle)
//     proto_err : sticky, a valid strobe arrived while waiting on latency
//     rd_cnt    : completed reads, wrapping
//     wr_cnt    : completed writes, wrapping
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   mr_idle  | nothing outstanding, a valid strobe is accepted
//   mr_busy  | request latched, wait counter running down to 1
//   mr_resp  | ready pulse; read data out or write commit; may accept again
module dm_mem_responder_downstream
  import cache_def::*;
#(
  parameter int LATENCY = MEM_LATENCY_DEFAULT,
  parameter int IDX_W   = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  mem_req_type  mem_req,
  output mem_data_type mem_data,
  output logic         busy,
  output logic         proto_err,
  output logic [31:0]  rd_cnt,
  output logic [31:0]  wr_cnt
);

  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  // With a single-cycle latency the wait state is skipped entirely.
  localparam mem_resp_state_type ACCEPT_STATE = (LATENCY == 1) ? mr_resp : mr_busy;

  mem_resp_state_type state, state_nxt;
  logic [7:0]         cnt, cnt_nxt;
  logic [IDX_W-1:0]   idx_q;
  logic [127:0]       data_q;
  logic               rw_q;
  logic               accept;
  logic               we;
  logic [127:0]       rd_data;
  logic [IDX_W-1:0]   req_idx;

  assign req_idx = mem_req.addr[IDX_W+3:4];

  // Offset bits and alias bits above the index carry no information here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_req.addr[31:IDX_W+4], mem_req.addr[3:0]};

  dm_mem_array_downstream #(
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (idx_q),
    .wdata (data_q),
    .raddr (idx_q),
    .rdata (rd_data)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      mr_idle: begin
        if (mem_req.valid) begin
          accept    = 1'b1;
          state_nxt = ACCEPT_STATE;
          cnt_nxt   = CNT_LOAD;
        end
      end
      mr_busy: begin
        cnt_nxt = cnt - 8'd1;
        if (cnt == 8'd1) begin
          state_nxt = mr_resp;
        end
      end
      mr_resp: begin
        // Back-to-back acceptance lets the cache's write-back be followed
        // directly by its allocate read.
        if (mem_req.valid) begin
          accept    = 1'b1;
          state_nxt = ACCEPT_STATE;
          cnt_nxt   = CNT_LOAD;
        end else begin
          state_nxt = mr_idle;
        end
      end
      default: begin
        state_nxt = mr_idle;
      end
    endcase
  end

  always_comb begin
    mem_data       = '0;
    mem_data.ready = (state == mr_resp);
    if ((state == mr_resp) && !rw_q) begin
      mem_data.data = rd_data;
    end
  end

  assign busy = (state != mr_idle);

  // A reset landing in the response cycle must not commit the write.
  assign we = (state == mr_resp) && rw_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= mr_idle;
      cnt       <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      rw_q      <= 1'b0;
      proto_err <= 1'b0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        idx_q  <= req_idx;
        data_q <= mem_req.data;
        rw_q   <= mem_req.rw;
      end
      if (mem_req.valid && (state == mr_busy)) begin
        proto_err <= 1'b1;
      end
      if (state == mr_resp) begin
        if (rw_q) begin
          wr_cnt <= wr_cnt + 32'd1;
        end else begin
          rd_cnt <= rd_cnt + 32'd1;
        end
      end
    end
  end

endmodule
